// File: rtl/usb_tx.sv
// USB 2.0 LS/FS transmitter: SYNC, bit-stuffed NRZI data (LSB first) and EOP onto D+/D-.
// Optional packet abort (bit-stuff violation then EOP) built when USB_TX_ABORT_EN is defined.
package types;
  typedef enum logic [1:0] {
    D_SE0 = 2'b00,
    D_K   = 2'b01,
    D_J   = 2'b10
  } d_port_t;
endpackage

module usb_tx #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic          clk,
  input  logic          rstx,
  input  logic [7:0]    tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
`ifdef USB_TX_ABORT_EN
  input  logic          tx_abort,
`endif
  output types::d_port_t d,
  output logic          oe,
  output logic          active
);
  import types::*;

  localparam int unsigned DW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP_SE0,
    EOP_J
`ifdef USB_TX_ABORT_EN
    , ABORT
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      byte_q, byte_d;
  logic [2:0]      ones_q, ones_d;
  d_port_t         line_q, line_d;
  logic            oe_q, oe_d;
  logic            act_q, act_d;
`ifdef USB_TX_ABORT_EN
  logic            abort_q, abort_d;
  logic            abort_req;
`endif

  logic            bnd;
  logic            last;
  logic            stuff;
  logic            send;
  logic            sbit;
  logic [2:0]      nxt;

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      ones_q  <= '0;
      line_q  <= D_J;
      oe_q    <= 1'b0;
      act_q   <= 1'b0;
`ifdef USB_TX_ABORT_EN
      abort_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      ones_q  <= ones_d;
      line_q  <= line_d;
      oe_q    <= oe_d;
      act_q   <= act_d;
`ifdef USB_TX_ABORT_EN
      abort_q <= abort_d;
`endif
    end
  end

  // Decisions are taken on the last clock of each bit period (bnd); the stuff
  // check precedes the load point so a stuff bit after a byte's last '1' delays it.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q + DW'(1);
    bit_d    = bit_q;
    byte_d   = byte_q;
    ones_d   = ones_q;
    line_d   = line_q;
    oe_d     = oe_q;
    act_d    = act_q;
    tx_ready = 1'b0;
    send     = 1'b0;
    sbit     = 1'b0;
    bnd      = &div_q;
    last     = (bit_q == 3'd7);
    stuff    = (ones_q == 3'd6);
    nxt      = bit_q + 3'd1;
`ifdef USB_TX_ABORT_EN
    abort_d   = abort_q;
    abort_req = abort_q | tx_abort;
`endif

    unique case (state_q)
      IDLE: begin
        div_d  = '0;
        ones_d = '0;
        line_d = D_J;
        oe_d   = 1'b0;
        act_d  = 1'b0;
`ifdef USB_TX_ABORT_EN
        abort_d = 1'b0;
`endif
        if (tx_valid) begin
          state_d = SYNC;
          byte_d  = 8'h80;
          bit_d   = '0;
          send    = 1'b1;
          sbit    = 1'b0;
          oe_d    = 1'b1;
          act_d   = 1'b1;
        end
      end
      SYNC, DATA: begin
`ifdef USB_TX_ABORT_EN
        abort_d = abort_req;
`endif
        if (bnd) begin
`ifdef USB_TX_ABORT_EN
          if (abort_req) begin
            state_d = ABORT;
            bit_d   = '0;
            abort_d = 1'b0;
          end else
`endif
          if (stuff) begin
            send = 1'b1;
            sbit = 1'b0;
          end else if (!last) begin
            bit_d = nxt;
            send  = 1'b1;
            sbit  = byte_q[nxt];
          end else if (tx_valid) begin
            tx_ready = 1'b1;
            state_d  = DATA;
            byte_d   = tx_data;
            bit_d    = '0;
            send     = 1'b1;
            sbit     = tx_data[0];
          end else begin
            state_d = EOP_SE0;
            bit_d   = '0;
            line_d  = D_SE0;
          end
        end
      end
      EOP_SE0: begin
        if (bnd) begin
          bit_d = nxt;
          if (bit_q[0]) begin
            state_d = EOP_J;
            line_d  = D_J;
          end
        end
      end
      EOP_J: begin
        if (bnd) begin
          state_d = IDLE;
          div_d   = '0;
          oe_d    = 1'b0;
          act_d   = 1'b0;
        end
      end
`ifdef USB_TX_ABORT_EN
      ABORT: begin
        if (bnd) begin
          if (last) begin
            state_d = EOP_SE0;
            bit_d   = '0;
            line_d  = D_SE0;
          end else begin
            bit_d = nxt;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (send) begin
      if (!sbit) begin
        line_d = (line_q == D_K) ? D_J : D_K;
        ones_d = '0;
      end else begin
        ones_d = ones_q + 3'd1;
      end
    end
  end

  assign d      = line_q;
  assign oe     = oe_q;
  assign active = act_q;

endmodule
